// File: rtl/rv64g_mp_regfile.sv
// Multi-port register file with per-register lock counters for issue/write-back tracking.
// Define RV64G_MP_REGFILE_BYPASS_EN to forward same-cycle write-back data and busy state to reads.
module rv64g_mp_regfile #(
  parameter int NUM_REGS      = 32,
  parameter int XLEN          = 64,
  parameter int NUM_RD        = 3,
  parameter int NUM_WB        = 2,
  parameter int LOCK_CNT_W    = 2,
  parameter bit HARDWIRE_ZERO = 1'b1,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   lock_en_i,
  input  logic [AW-1:0]          lock_addr_i,
  output logic                   lock_ready_o,
  input  logic [NUM_WB-1:0]      wb_en_i,
  input  logic [NUM_WB*AW-1:0]   wb_addr_i,
  input  logic [NUM_WB*XLEN-1:0] wb_data_i,
  input  logic [NUM_RD*AW-1:0]   rs_addr_i,
  output logic [NUM_RD*XLEN-1:0] rs_data_o,
  output logic [NUM_RD-1:0]      rs_busy_o,
  output logic [NUM_REGS-1:0]    locks_o,
  output logic                   err_o
);
  localparam int HW = $clog2(NUM_WB + 1);
  localparam int SW = ((LOCK_CNT_W > HW) ? LOCK_CNT_W : HW) + 1;
  localparam logic [LOCK_CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]                     r_mem [NUM_REGS];
  logic [NUM_REGS-1:0][LOCK_CNT_W-1:0] r_cnt;
  logic                                r_err;

  logic [NUM_WB-1:0][AW-1:0]           w_wb_addr;
  logic [NUM_WB-1:0][XLEN-1:0]         w_wb_data;
  logic [NUM_WB-1:0]                   w_wb_vld;
  logic [NUM_RD-1:0][AW-1:0]           w_rs_addr;
  logic [NUM_RD-1:0][XLEN-1:0]         w_rs_data;
  logic [NUM_REGS-1:0][HW-1:0]         w_hits;
  logic [NUM_REGS-1:0][SW-1:0]         w_up;
  logic [NUM_REGS-1:0][LOCK_CNT_W-1:0] w_cnt_nxt;
  logic [NUM_REGS-1:0]                 w_under;
  logic [NUM_REGS-1:0]                 w_nz;
  logic                                w_lock_zero;
  logic                                w_lock_fire;

  assign w_wb_addr = wb_addr_i;
  assign w_wb_data = wb_data_i;
  assign w_rs_addr = rs_addr_i;
  assign w_lock_zero = HARDWIRE_ZERO && (lock_addr_i == '0);

  // Drop write-backs during reset and to a hardwired r0 before they reach any counter or mem.
  always_comb begin
    for (int p = 0; p < NUM_WB; p++)
      w_wb_vld[p] = wb_en_i[p] & ~srst_i & ~(HARDWIRE_ZERO && (w_wb_addr[p] == '0));
  end

  // Ready looks only at registered counts, so a saturated register stalls even if freed this cycle.
  always_comb begin
    if (srst_i)           lock_ready_o = 1'b0;
    else if (w_lock_zero) lock_ready_o = 1'b1;
    else                  lock_ready_o = (r_cnt[lock_addr_i] != CNT_MAX);
  end

  assign w_lock_fire = lock_en_i & lock_ready_o & ~w_lock_zero;

  always_comb begin
    for (int g = 0; g < NUM_REGS; g++) begin
      w_hits[g] = '0;
      for (int p = 0; p < NUM_WB; p++)
        if (w_wb_vld[p] && (w_wb_addr[p] == AW'(g))) w_hits[g] = w_hits[g] + HW'(1);
      w_up[g]      = SW'(r_cnt[g]) + SW'(w_lock_fire && (lock_addr_i == AW'(g)));
      w_under[g]   = SW'(w_hits[g]) > w_up[g];
      w_cnt_nxt[g] = w_under[g] ? '0 : LOCK_CNT_W'(w_up[g] - SW'(w_hits[g]));
      w_nz[g]      = (r_cnt[g] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int g = 0; g < NUM_REGS; g++) r_mem[g] <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      // Later ports overwrite earlier ones, giving the highest index priority.
      for (int p = 0; p < NUM_WB; p++)
        if (w_wb_vld[p]) r_mem[w_wb_addr[p]] <= w_wb_data[p];
      r_cnt <= w_cnt_nxt;
      if (|w_under) r_err <= 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      w_rs_data[r] = r_mem[w_rs_addr[r]];
      rs_busy_o[r] = w_nz[w_rs_addr[r]];
`ifdef RV64G_MP_REGFILE_BYPASS_EN
      // Busy reflects the count after this cycle's write-backs, ignoring the same-cycle lock.
      rs_busy_o[r] = SW'(r_cnt[w_rs_addr[r]]) > SW'(w_hits[w_rs_addr[r]]);
      for (int p = 0; p < NUM_WB; p++)
        if (w_wb_vld[p] && (w_wb_addr[p] == w_rs_addr[r])) w_rs_data[r] = w_wb_data[p];
`endif
      if (HARDWIRE_ZERO && (w_rs_addr[r] == '0)) w_rs_data[r] = '0;
      if (srst_i) begin
        w_rs_data[r] = '0;
        rs_busy_o[r] = 1'b1;
      end
    end
  end

  assign rs_data_o = w_rs_data;
  assign locks_o   = srst_i ? '1 : w_nz;
  assign err_o     = r_err;

endmodule
